h264_intra4x4_feedback: RTL and testbench

Reconstructed-pixel feedback responder for the H.264 intra 4x4 path. It accepts four reconstructed rows per 4x4 sub-block from the inverse-transform/reconstruction stage and commits the sub-block's right column and bottom row into left/top neighbour buffers. It then drives the `fbpending`/`fbstrobe` handshake that the intra4x4 controller waits on before predicting the next sub-block. It also serves the controller's neighbour reads (top, left, availability) for prediction.

---
 rtl/h264_intra4x4_feedback.sv | 238 +++++++++++++++++++++++
 tb/tb_h264_intra4x4_feedback.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/h264_intra4x4_feedback.sv
// ---------------------------------------------------------------------------
// h264_intra4x4_feedback
//
// Reconstructed-pixel feedback responder for the H.264 intra 4x4 path.
// Collects the four reconstructed rows of a 4x4 sub-block, commits its bottom
// row into the top-neighbour buffer and its right column into the
// left-neighbour buffer, then pulses o_fbstrobe. It also serves neighbour
// reads (top, left, availability) for the intra4x4 predictor.
//
// Optional feature macro: H264_FB_TOPRIGHT_EN adds the top-right neighbour
// read outputs (o_topright_out / o_topright_avail).
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   i_frame_start       pulse: mbx <= 0, row_nz <= 0
//   i_newline           pulse: mbx <= 0, row_nz <= 1
//   i_mb_done           pulse: mbx <= mbx+1 (saturating)
//   i_mb_width[6:0]     macroblocks in the current line
//   i_rec_valid/o_rec_ready, i_rec_data[31:0], i_rec_submb[3:0]
//                       reconstructed row stream (pixel 0 in bits [7:0])
//   o_fbpending         sub-block collection/commit in progress
//   o_fbstrobe          one-cycle pulse: sub-block committed
//   i_nb_rd, i_nb_submb neighbour read request for a sub-block
//   o_nb_valid          one-cycle pulse: read data valid
//   o_top_out, o_left_out, o_top_avail, o_left_avail  neighbour data/flags
// ---------------------------------------------------------------------------
module h264_intra4x4_feedback #(
  parameter int MB_WIDTH_MAX = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_frame_start,
  input  logic        i_newline,
  input  logic        i_mb_done,
  input  logic [6:0]  i_mb_width,
  input  logic        i_rec_valid,
  output logic        o_rec_ready,
  input  logic [31:0] i_rec_data,
  input  logic [3:0]  i_rec_submb,
  output logic        o_fbpending,
  output logic        o_fbstrobe,
  input  logic        i_nb_rd,
  input  logic [3:0]  i_nb_submb,
  output logic        o_nb_valid,
  output logic [31:0] o_top_out,
  output logic [31:0] o_left_out,
  output logic        o_top_avail,
  output logic        o_left_avail
`ifdef H264_FB_TOPRIGHT_EN
  ,
  output logic [31:0] o_topright_out,
  output logic        o_topright_avail
`endif
);

  localparam int                DEPTH    = MB_WIDTH_MAX * 4;
  localparam int                MBX_W    = $clog2(MB_WIDTH_MAX);
  localparam int                ADDR_W   = MBX_W + 2;
  localparam logic [MBX_W-1:0]  MBX_LAST = MBX_W'(MB_WIDTH_MAX - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_STROBE} state_t;

  state_t             r_state, w_state_nxt;
  logic               w_accept;
  logic [1:0]         r_row_cnt;
  logic [MBX_W-1:0]   r_mbx;
  logic               r_row_nz;

  // Sub-block capture registers.
  logic [ADDR_W-1:0]  r_col;
  logic [1:0]         r_yy;
  logic [7:0]         r_p3 [4];
  logic [31:0]        r_row3;

  // Neighbour buffers.
  logic [31:0]        r_top  [DEPTH];
  logic [31:0]        r_left [4];

  // Read-side registers.
  logic               r_nb_valid;
  logic [31:0]        r_top_out, r_left_out;
  logic               r_top_avail, r_left_avail;

  // Sub-block coordinates of the read request: xx={s[2],s[0]}, yy={s[3],s[1]}.
  logic [1:0]         w_nb_xx, w_nb_yy, w_rec_xx;
  logic [ADDR_W-1:0]  w_nb_col;

  assign w_nb_xx  = {i_nb_submb[2], i_nb_submb[0]};
  assign w_nb_yy  = {i_nb_submb[3], i_nb_submb[1]};
  assign w_rec_xx = {i_rec_submb[2], i_rec_submb[0]};
  assign w_nb_col = {r_mbx, w_nb_xx};
  assign w_accept = i_rec_valid && o_rec_ready;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    o_rec_ready = 1'b0;
    o_fbpending = 1'b0;
    o_fbstrobe  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_rec_ready = 1'b1;
        if (i_rec_valid) w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        o_rec_ready = 1'b1;
        o_fbpending = 1'b1;
        if (i_rec_valid && r_row_cnt == 2'd3) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        o_fbpending = 1'b1;
        w_state_nxt = S_STROBE;
      end
      S_STROBE: begin
        o_fbstrobe  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Row counter: 1 after row 0, wraps back to 0 after row 3.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values of the others.
    if (reset)                                  r_row_cnt <= 2'd0;
    else if (w_accept && r_state == S_IDLE)     r_row_cnt <= 2'd1;
    else if (w_accept)                          r_row_cnt <= r_row_cnt + 2'd1;
  end

  // Capture datapath. Column and row index are frozen at row 0, so an mbx
  // change during collection does not move the write target.
  // NOTE: pure data registers carry no reset; a reset only has to return
  // the control state, which already discards any partial sub-block.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_p3[r_row_cnt] <= i_rec_data[31:24];
      if (r_state == S_IDLE) begin
        r_col <= {r_mbx, w_rec_xx};
        r_yy  <= {i_rec_submb[3], i_rec_submb[1]};
      end
      if (r_state == S_COLLECT && r_row_cnt == 2'd3) r_row3 <= i_rec_data;
    end
  end

  // Buffer commit. Reads in the read block below see pre-edge contents,
  // giving read-before-write on a same-address collision.
  // NOTE: the buffers are RAMs and are deliberately never reset.
  always_ff @(posedge clk) begin
    if (!reset && r_state == S_WRITE) begin
      r_top[r_col]  <= r_row3;
      r_left[r_yy]  <= {r_p3[3], r_p3[2], r_p3[1], r_p3[0]};
    end
  end

  // ---------------- Macroblock position ----------------
  // Priority: frame_start > newline > mb_done.
  always_ff @(posedge clk) begin
    if (reset || i_frame_start) begin
      r_mbx    <= '0;
      r_row_nz <= 1'b0;
    end else if (i_newline) begin
      r_mbx    <= '0;
      r_row_nz <= 1'b1;
    end else if (i_mb_done && r_mbx != MBX_LAST) begin
      r_mbx    <= r_mbx + 1'b1;
    end
  end

  // ---------------- Neighbour reads ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nb_valid   <= 1'b0;
      r_top_out    <= '0;
      r_left_out   <= '0;
      r_top_avail  <= 1'b0;
      r_left_avail <= 1'b0;
    end else begin
      r_nb_valid <= i_nb_rd;
      if (i_nb_rd) begin
        r_top_out    <= r_top[w_nb_col];
        r_left_out   <= r_left[w_nb_yy];
        r_left_avail <= (w_nb_xx != 2'd0) || (r_mbx != '0);
        r_top_avail  <= (w_nb_yy != 2'd0) || r_row_nz;
      end
    end
  end

  assign o_nb_valid   = r_nb_valid;
  assign o_top_out    = r_top_out;
  assign o_left_out   = r_left_out;
  assign o_top_avail  = r_top_avail;
  assign o_left_avail = r_left_avail;

`ifdef H264_FB_TOPRIGHT_EN
  // Top-right word sits one column to the right; for xx=3 that is the first
  // column of the next macroblock. Past the end of the buffer it reads 0.
  localparam logic [ADDR_W:0] TR_LIMIT = DEPTH[ADDR_W:0];

  logic [ADDR_W:0]  w_tr_addr;
  logic [6:0]       w_mbw_last;
  logic             w_tr_excl;
  logic [31:0]      r_topright_out;
  logic             r_topright_avail;

  assign w_tr_addr  = {1'b0, w_nb_col} + 1'b1;
  assign w_mbw_last = i_mb_width - 7'd1;
  // Sub-blocks whose top-right lies in a not-yet-decoded area.
  assign w_tr_excl  = (i_nb_submb == 4'd3)  || (i_nb_submb == 4'd7) ||
                      (i_nb_submb == 4'd11) || (i_nb_submb == 4'd13) ||
                      (i_nb_submb == 4'd15);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_topright_out   <= '0;
      r_topright_avail <= 1'b0;
    end else if (i_nb_rd) begin
      r_topright_out   <= (w_tr_addr < TR_LIMIT) ? r_top[w_tr_addr[ADDR_W-1:0]] : '0;
      r_topright_avail <= !w_tr_excl && ((w_nb_yy != 2'd0) || r_row_nz) &&
                          !(i_nb_submb == 4'd5 && 7'(r_mbx) == w_mbw_last);
    end
  end

  assign o_topright_out   = r_topright_out;
  assign o_topright_avail = r_topright_avail;
`else
  logic w_unused_mb_width;
  assign w_unused_mb_width = ^i_mb_width;
`endif

endmodule

// File: tb/tb_h264_intra4x4_feedback.sv
// ---------------------------------------------------------------------------
// Testbench for h264_intra4x4_feedback: directed scenarios followed by a
// randomized mix of sub-block commits, neighbour reads and position pulses,
// all checked against a behavioural model of the neighbour buffers.
// ---------------------------------------------------------------------------
module tb_h264_intra4x4_feedback;

  localparam int MBW   = 120;
  localparam int DEPTH = MBW * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_frame_start, i_newline, i_mb_done;
  logic [6:0]  i_mb_width;
  logic        i_rec_valid;
  logic        o_rec_ready;
  logic [31:0] i_rec_data;
  logic [3:0]  i_rec_submb;
  logic        o_fbpending, o_fbstrobe;
  logic        i_nb_rd;
  logic [3:0]  i_nb_submb;
  logic        o_nb_valid;
  logic [31:0] o_top_out, o_left_out;
  logic        o_top_avail, o_left_avail;
`ifdef H264_FB_TOPRIGHT_EN
  logic [31:0] o_topright_out;
  logic        o_topright_avail;
`endif

  always #5 clk = ~clk;

  h264_intra4x4_feedback #(.MB_WIDTH_MAX(MBW)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_frame_start  (i_frame_start),
    .i_newline      (i_newline),
    .i_mb_done      (i_mb_done),
    .i_mb_width     (i_mb_width),
    .i_rec_valid    (i_rec_valid),
    .o_rec_ready    (o_rec_ready),
    .i_rec_data     (i_rec_data),
    .i_rec_submb    (i_rec_submb),
    .o_fbpending    (o_fbpending),
    .o_fbstrobe     (o_fbstrobe),
    .i_nb_rd        (i_nb_rd),
    .i_nb_submb     (i_nb_submb),
    .o_nb_valid     (o_nb_valid),
    .o_top_out      (o_top_out),
    .o_left_out     (o_left_out),
    .o_top_avail    (o_top_avail),
    .o_left_avail   (o_left_avail)
`ifdef H264_FB_TOPRIGHT_EN
    ,
    .o_topright_out   (o_topright_out),
    .o_topright_avail (o_topright_avail)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  logic [31:0] top_m  [DEPTH];
  bit          top_k  [DEPTH];
  logic [31:0] left_m [4];
  bit          left_k [4];
  int          mbx_m  = 0;
  bit          rnz_m  = 0;
  logic [31:0] rw [4];

  function automatic int sb_x(input logic [3:0] s);
    return 2 * int'(s[2]) + int'(s[0]);
  endfunction

  function automatic int sb_y(input logic [3:0] s);
    return 2 * int'(s[3]) + int'(s[1]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl(input bit fs, input bit nl, input bit md);
    i_frame_start = fs; i_newline = nl; i_mb_done = md;
    tick();
    i_frame_start = 0; i_newline = 0; i_mb_done = 0;
    if (fs) begin mbx_m = 0; rnz_m = 0; end
    else if (nl) begin mbx_m = 0; rnz_m = 1; end
    else if (md && mbx_m < MBW - 1) mbx_m++;
  endtask

  // Sends rows rw[0..3] for sub-block sb with g0/g1/g2 idle cycles after
  // rows 0/1/2; optionally pulses mb_done together with row 1.
  task automatic send_sb(input logic [3:0] sb, input int g0, input int g1,
                         input int g2, input bit mbd_mid);
    int gaps [3];
    int col;
    gaps[0] = g0; gaps[1] = g1; gaps[2] = g2;
    col = mbx_m * 4 + sb_x(sb);
    for (int r = 0; r < 4; r++) begin
      check("rec_ready_before_row", o_rec_ready, 1);
      i_rec_valid = 1;
      i_rec_data  = rw[r];
      i_rec_submb = (r == 0) ? sb : 4'($urandom);
      i_mb_done   = mbd_mid && (r == 1);
      tick();
      i_rec_valid = 0;
      i_mb_done   = 0;
      if (mbd_mid && r == 1 && mbx_m < MBW - 1) mbx_m++;
      check("fbpending_after_row", o_fbpending, 1);
      check("fbstrobe_after_row", o_fbstrobe, 0);
      if (r < 3) begin
        for (int g = 0; g < gaps[r]; g++) begin
          tick();
          check("fbpending_gap", o_fbpending, 1);
          check("rec_ready_gap", o_rec_ready, 1);
          check("fbstrobe_gap", o_fbstrobe, 0);
        end
      end
    end
    check("rec_ready_write", o_rec_ready, 0);
    tick();
    check("fbpending_strobe", o_fbpending, 0);
    check("fbstrobe_strobe", o_fbstrobe, 1);
    check("rec_ready_strobe", o_rec_ready, 0);
    tick();
    check("fbstrobe_idle", o_fbstrobe, 0);
    check("rec_ready_idle", o_rec_ready, 1);
    top_m[col]  = rw[3];
    top_k[col]  = 1;
    left_m[sb_y(sb)] = {rw[3][31:24], rw[2][31:24], rw[1][31:24], rw[0][31:24]};
    left_k[sb_y(sb)] = 1;
  endtask

  task automatic nb_read(input logic [3:0] s);
    int xx, yy, col;
    xx  = sb_x(s);
    yy  = sb_y(s);
    col = mbx_m * 4 + xx;
    i_nb_rd = 1; i_nb_submb = s;
    tick();
    i_nb_rd = 0; i_nb_submb = 4'($urandom);
    check("nb_valid", o_nb_valid, 1);
    check("top_avail", o_top_avail, (yy != 0) || rnz_m);
    check("left_avail", o_left_avail, (xx != 0) || (mbx_m != 0));
    if (top_k[col]) check("top_out", o_top_out, top_m[col]);
    if (left_k[yy]) check("left_out", o_left_out, left_m[yy]);
`ifdef H264_FB_TOPRIGHT_EN
    begin
      bit excl, avl;
      excl = (s == 3) || (s == 7) || (s == 11) || (s == 13) || (s == 15);
      avl  = !excl && ((yy != 0) || rnz_m) &&
             !(s == 5 && mbx_m == int'(i_mb_width) - 1);
      check("topright_avail", o_topright_avail, avl);
      if (col + 1 < DEPTH && top_k[col + 1])
        check("topright_out", o_topright_out, top_m[col + 1]);
    end
`endif
    tick();
    check("nb_valid_pulse", o_nb_valid, 0);
    if (top_k[col]) check("top_out_hold", o_top_out, top_m[col]);
  endtask

  task automatic rand_rows();
    for (int r = 0; r < 4; r++) rw[r] = $urandom;
  endtask

  initial begin
    reset = 1; i_frame_start = 0; i_newline = 0; i_mb_done = 0;
    i_mb_width = 7'd4; i_rec_valid = 0; i_rec_data = '0; i_rec_submb = '0;
    i_nb_rd = 0; i_nb_submb = '0;
    repeat (3) tick();
    check("rst_rec_ready", o_rec_ready, 1);
    check("rst_fbpending", o_fbpending, 0);
    check("rst_fbstrobe", o_fbstrobe, 0);
    check("rst_nb_valid", o_nb_valid, 0);
    check("rst_top_out", o_top_out, 0);
    check("rst_left_out", o_left_out, 0);
    check("rst_top_avail", o_top_avail, 0);
    check("rst_left_avail", o_left_avail, 0);
    reset = 0;
    tick();

    // Basic commit with the reference rows, then neighbour reads.
    rw[0] = 32'h03020100; rw[1] = 32'h13121110;
    rw[2] = 32'h23222120; rw[3] = 32'h33323130;
    send_sb(4'd0, 0, 0, 0, 0);
    nb_read(4'd2);
    nb_read(4'd1);

    // Availability at frame start and after newline + mb_done.
    ctrl(1, 0, 0);
    nb_read(4'd0);
    ctrl(0, 1, 0);
    ctrl(0, 0, 1);
    nb_read(4'd0);

    // Three-cycle gap between rows 1 and 2.
    rand_rows();
    send_sb(4'd6, 0, 3, 0, 0);
    nb_read(4'd6);
    nb_read(4'd14);

    // Reset after row 2: partial sub-block dropped.
    for (int r = 0; r < 3; r++) begin
      i_rec_valid = 1; i_rec_data = $urandom; i_rec_submb = 4'd9;
      tick();
    end
    i_rec_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    mbx_m = 0; rnz_m = 0;
    check("midrst_fbpending", o_fbpending, 0);
    check("midrst_rec_ready", o_rec_ready, 1);
    check("midrst_top_out", o_top_out, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("midrst_no_strobe", o_fbstrobe, 0);
      check("midrst_no_pending", o_fbpending, 0);
    end
    rand_rows();
    send_sb(4'd9, 0, 0, 0, 0);
    nb_read(4'd9);
    nb_read(4'd12);

    // Position priority.
    ctrl(0, 0, 1);
    ctrl(0, 1, 1);
    nb_read(4'd0);
    ctrl(0, 0, 1);
    ctrl(1, 1, 1);
    nb_read(4'd0);

    // mb_done during collection: write goes to the row-0 column.
    ctrl(0, 1, 0);
    rand_rows();
    send_sb(4'd0, 0, 1, 0, 1);
    ctrl(0, 1, 0);
    nb_read(4'd2);

    // Saturation of mbx.
    for (int k = 0; k < MBW + 5; k++) ctrl(0, 0, 1);
    rand_rows();
    send_sb(4'd5, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) ctrl(0, 0, 1);
    nb_read(4'd7);

`ifdef H264_FB_TOPRIGHT_EN
    i_mb_width = 7'd2;
    ctrl(0, 1, 0);
    ctrl(0, 0, 1);
    rand_rows();
    send_sb(4'd4, 0, 0, 0, 0);
    nb_read(4'd5);
    nb_read(4'd1);
`endif

    // Randomized mix.
    for (int it = 0; it < 200; it++) begin
      int act;
      act = $urandom_range(0, 11);
      if (act <= 4) begin
        rand_rows();
        send_sb(4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 5) == 0);
      end else if (act <= 8) begin
        i_mb_width = 7'($urandom_range(1, MBW));
        nb_read(4'($urandom));
      end else if (act <= 10) begin
        ctrl(0, 0, 1);
      end else begin
        ctrl($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 1'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
